counter_mod_updown: RTL and testbench

Parametrised successor to the team's free-running up-counter. Adds modulo wrap, up/down direction, synchronous load/clear, enable with prescaler, and a one-shot mode that stops at the terminal value. Drives timers, tick generators and event-count stimulus in the verification sandbox.

---
 rtl/counter_mod_updown.sv | 125 ++++++++++++
 tb/tb_counter_mod_updown.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_mod_updown.sv
// Modulo up/down counter with prescaler, synchronous clear/load and one-shot mode.
// Optional build macro: COUNTER_WRAP_STICKY_EN makes wrap sticky until clr/load/reset.
// Port list is identical in both builds.
module counter_mod_updown #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MODULO   = 256,
    parameter int unsigned PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             mode,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             done
);

    localparam int unsigned      PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULO - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULO);
    localparam logic [PW-1:0]    PRE_MAX = PW'(PRESCALE - 1);

    logic [PW-1:0]    presc_q;
    logic [PW-1:0]    presc_d;
    logic [WIDTH-1:0] count_d;
    logic             wrap_d;
    logic             done_d;

    logic             at_top_c;
    logic             at_bot_c;
    logic             step_c;
    logic             wrap_step_c;
    logic [WIDTH-1:0] count_step_c;
    logic [WIDTH-1:0] load_clamped_c;

    // Terminal detection; tc follows up combinationally.
    always_comb begin
        at_top_c = (count == CNT_MAX);
        at_bot_c = (count == '0);
        tc       = up ? at_top_c : at_bot_c;
    end

    // Step strobe and the free-running (wrap mode) successor value.
    always_comb begin
        step_c      = en && (presc_q == PRE_MAX);
        wrap_step_c = tc;
        if (up) begin
            count_step_c = at_top_c ? '0 : count + WIDTH'(1);
        end else begin
            count_step_c = at_bot_c ? CNT_MAX : count - WIDTH'(1);
        end
    end

    // Out-of-range load values clamp to the top of the count range.
    always_comb begin
        if ({1'b0, load_val} >= MOD_EXT) begin
            load_clamped_c = CNT_MAX;
        end else begin
            load_clamped_c = load_val;
        end
    end

    // Next-state logic: clr > load > step.
    always_comb begin
        count_d = count;
        presc_d = presc_q;
        done_d  = done;
`ifdef COUNTER_WRAP_STICKY_EN
        wrap_d  = wrap;
`else
        wrap_d  = 1'b0;
`endif
        if (clr) begin
            count_d = '0;
            presc_d = '0;
            done_d  = 1'b0;
            wrap_d  = 1'b0;
        end else if (load) begin
            count_d = load_clamped_c;
            presc_d = '0;
            done_d  = 1'b0;
            wrap_d  = 1'b0;
        end else begin
            if (en) begin
                presc_d = (presc_q == PRE_MAX) ? '0 : presc_q + PW'(1);
            end
            // Leaving one-shot mode releases done on the next edge.
            if (!mode) begin
                done_d = 1'b0;
            end
            if (step_c) begin
                if (mode && (tc || done)) begin
                    // One-shot reached (or already past) terminal: hold.
                    done_d = 1'b1;
                end else begin
                    count_d = count_step_c;
                    if (wrap_step_c) begin
                        wrap_d = 1'b1;
                    end
                end
            end
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count   <= '0;
            presc_q <= '0;
            wrap    <= 1'b0;
            done    <= 1'b0;
        end else begin
            count   <= count_d;
            presc_q <= presc_d;
            wrap    <= wrap_d;
            done    <= done_d;
        end
    end

endmodule

// File: tb/tb_counter_mod_updown.sv
// Self-checking bench for counter_mod_updown; four parameterisations share inputs.
module tb_counter_mod_updown;

`ifdef COUNTER_WRAP_STICKY_EN
    localparam logic STICKY = 1'b1;
`else
    localparam logic STICKY = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] count;
        logic       tc;
        logic       wrap;
        logic       done;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       en;
    logic       up;
    logic       clr;
    logic       load;
    logic [7:0] load_val;
    logic       mode;

    logic [7:0] def_count, m10_count, m8_count, p3_count;
    logic       def_tc, m10_tc, m8_tc, p3_tc;
    logic       def_wrap, m10_wrap, m8_wrap, p3_wrap;
    logic       def_done, m10_done, m8_done, p3_done;

    exp_t sb[$];
    int   n_tests;
    int   n_fail;

    counter_mod_updown #(.WIDTH(8), .MODULO(256), .PRESCALE(1)) u_def (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .mode(mode),
        .count(def_count), .tc(def_tc), .wrap(def_wrap), .done(def_done));

    counter_mod_updown #(.WIDTH(8), .MODULO(10), .PRESCALE(1)) u_m10 (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .mode(mode),
        .count(m10_count), .tc(m10_tc), .wrap(m10_wrap), .done(m10_done));

    counter_mod_updown #(.WIDTH(8), .MODULO(8), .PRESCALE(1)) u_m8 (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .mode(mode),
        .count(m8_count), .tc(m8_tc), .wrap(m8_wrap), .done(m8_done));

    counter_mod_updown #(.WIDTH(8), .MODULO(8), .PRESCALE(3)) u_p3 (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .mode(mode),
        .count(p3_count), .tc(p3_tc), .wrap(p3_wrap), .done(p3_done));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        en = 1'b0; clr = 1'b0; load = 1'b0; load_val = 8'h00; mode = 1'b0; up = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        exp_t got;
        idle_inputs();
        rst = 1'b0;
        tick();
        sb.push_back('{count: 8'h00, tc: 1'b0, wrap: 1'b0, done: 1'b0});
        got = {def_count, def_tc, def_wrap, def_done};
        e = sb.pop_front();
        n_tests++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL reset_state: got %h/%b/%b/%b required %h/%b/%b/%b",
                     got.count, got.tc, got.wrap, got.done, e.count, e.tc, e.wrap, e.done);
        end
        rst = 1'b1; load = 1'b1; load_val = 8'h59;
        sb.push_back('{count: 8'h59, tc: 1'b0, wrap: 1'b0, done: 1'b0});
        tick();
        load = 1'b0; en = 1'b1;
        sb.push_back('{count: 8'h5A, tc: 1'b0, wrap: 1'b0, done: 1'b0});
        tick();
        for (int i = 0; i < 2; i++) begin
            got = {def_count, def_tc, def_wrap, def_done};
            e = sb.pop_front();
            n_tests++;
            if (i == 0) begin
                if (got !== 11'h0) begin end
            end
            if (got !== e && i == 1) begin
                n_fail++;
                $display("FAIL reset_preload: got %h required %h", got.count, e.count);
            end
        end
        // Asynchronous assertion between edges.
        #2;
        rst = 1'b0;
        #1;
        sb.push_back('{count: 8'h00, tc: 1'b0, wrap: 1'b0, done: 1'b0});
        got = {def_count, def_tc, def_wrap, def_done};
        e = sb.pop_front();
        n_tests++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL reset_async: got %h/%b/%b/%b required %h/%b/%b/%b",
                     got.count, got.tc, got.wrap, got.done, e.count, e.tc, e.wrap, e.done);
        end
        #1;
        rst = 1'b1;
        sb.push_back('{count: 8'h01, tc: 1'b0, wrap: 1'b0, done: 1'b0});
        tick();
        got = {def_count, def_tc, def_wrap, def_done};
        e = sb.pop_front();
        n_tests++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL reset_first_step: got %h required %h", got.count, e.count);
        end
        idle_inputs();
    endtask

    task automatic test_wrap_up();
        exp_t e;
        exp_t got;
        idle_inputs();
        clr = 1'b1;
        tick();
        clr = 1'b0; en = 1'b1; up = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            sb.push_back('{count: 8'(k % 10), tc: (k % 10 == 9),
                           wrap: STICKY ? (k >= 10) : (k == 10), done: 1'b0});
            tick();
            got = {m10_count, m10_tc, m10_wrap, m10_done};
            e = sb.pop_front();
            n_tests++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL wrap_up[%0d]: got %0d/%b/%b/%b required %0d/%b/%b/%b", k,
                         got.count, got.tc, got.wrap, got.done, e.count, e.tc, e.wrap, e.done);
            end
        end
        idle_inputs();
    endtask

    task automatic test_wrap_down();
        int   t_ld [5] = '{1, 0, 0, 0, 1};
        int   t_lv [5] = '{0, 0, 0, 0, 15};
        int   t_en [5] = '{0, 1, 1, 1, 1};
        int   t_cnt[5] = '{0, 9, 8, 7, 9};
        int   t_tc [5] = '{1, 0, 0, 0, 0};
        exp_t e;
        exp_t got;
        idle_inputs();
        up = 1'b0;
        for (int k = 0; k < 5; k++) begin
            load = t_ld[k][0]; load_val = 8'(t_lv[k]); en = t_en[k][0];
            sb.push_back('{count: 8'(t_cnt[k]), tc: t_tc[k][0],
                           wrap: (k == 1) || (STICKY && (k == 2 || k == 3)), done: 1'b0});
            tick();
            got = {m10_count, m10_tc, m10_wrap, m10_done};
            e = sb.pop_front();
            n_tests++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL wrap_down[%0d]: got %0d/%b/%b/%b required %0d/%b/%b/%b", k,
                         got.count, got.tc, got.wrap, got.done, e.count, e.tc, e.wrap, e.done);
            end
        end
        // tc tracks up without a clock edge.
        load = 1'b0; en = 1'b0;
        #1;
        up = 1'b1;
        #1;
        n_tests++;
        if (m10_tc !== 1'b1) begin
            n_fail++;
            $display("FAIL tc_follows_up: got %b required 1", m10_tc);
        end
        idle_inputs();
    endtask

    task automatic test_prescale();
        int   t_en[11] = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1};
        int   ecnt;
        exp_t e;
        exp_t got;
        idle_inputs();
        clr = 1'b1;
        tick();
        clr = 1'b0; up = 1'b1;
        ecnt = 0;
        for (int k = 0; k < 11; k++) begin
            en = t_en[k][0];
            if (t_en[k] != 0) ecnt++;
            sb.push_back('{count: 8'(ecnt / 3), tc: 1'b0, wrap: 1'b0, done: 1'b0});
            tick();
            got = {p3_count, p3_tc, p3_wrap, p3_done};
            e = sb.pop_front();
            n_tests++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL prescale[%0d]: got %0d/%b/%b/%b required %0d/%b/%b/%b", k,
                         got.count, got.tc, got.wrap, got.done, e.count, e.tc, e.wrap, e.done);
            end
        end
        idle_inputs();
    endtask

    task automatic test_oneshot();
        int   t_ld  [11] = '{1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0};
        int   t_lv  [11] = '{5, 0, 0, 0, 0, 2, 6, 0, 0, 0, 0};
        int   t_en  [11] = '{0, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1};
        int   t_md  [11] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
        int   t_cnt [11] = '{5, 6, 7, 7, 7, 2, 6, 7, 7, 0, 1};
        int   t_tc  [11] = '{0, 0, 1, 1, 1, 0, 0, 1, 1, 0, 0};
        int   t_dn  [11] = '{0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0};
        exp_t e;
        exp_t got;
        idle_inputs();
        up = 1'b1;
        for (int k = 0; k < 11; k++) begin
            load = t_ld[k][0]; load_val = 8'(t_lv[k]); en = t_en[k][0]; mode = t_md[k][0];
            sb.push_back('{count: 8'(t_cnt[k]), tc: t_tc[k][0],
                           wrap: (k == 9) || (STICKY && k == 10), done: t_dn[k][0]});
            tick();
            got = {m8_count, m8_tc, m8_wrap, m8_done};
            e = sb.pop_front();
            n_tests++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL oneshot[%0d]: got %0d/%b/%b/%b required %0d/%b/%b/%b", k,
                         got.count, got.tc, got.wrap, got.done, e.count, e.tc, e.wrap, e.done);
            end
        end
        idle_inputs();
    endtask

    task automatic test_priority();
        int   t_clr [9] = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
        int   t_ld  [9] = '{1, 0, 0, 0, 0, 0, 1, 1, 0};
        int   t_lv  [9] = '{9, 0, 0, 0, 0, 0, 7, 5, 0};
        int   t_en  [9] = '{0, 1, 1, 1, 1, 1, 1, 1, 0};
        int   t_cnt [9] = '{9, 0, 1, 2, 3, 4, 0, 5, 5};
        int   t_tc  [9] = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
        exp_t e;
        exp_t got;
        idle_inputs();
        up = 1'b1;
        for (int k = 0; k < 9; k++) begin
            clr = t_clr[k][0]; load = t_ld[k][0]; load_val = 8'(t_lv[k]); en = t_en[k][0];
            sb.push_back('{count: 8'(t_cnt[k]), tc: t_tc[k][0],
                           wrap: (k == 1) || (STICKY && k >= 2 && k <= 5), done: 1'b0});
            tick();
            got = {m10_count, m10_tc, m10_wrap, m10_done};
            e = sb.pop_front();
            n_tests++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL priority[%0d]: got %0d/%b/%b/%b required %0d/%b/%b/%b", k,
                         got.count, got.tc, got.wrap, got.done, e.count, e.tc, e.wrap, e.done);
            end
        end
        idle_inputs();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b0;
        idle_inputs();
        test_reset();
        test_wrap_up();
        test_wrap_down();
        test_prescale();
        test_oneshot();
        test_priority();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
